cmd_proc_mc: RTL and testbench
==============================

# cmd_proc_mc

Parametrised command processor for the logic-analyzer core. It decodes 16-bit host commands from the UART wrapper, owns the trigger/capture configuration registers, and streams captured samples from a configurable number of channel RAMs back to the host. It sits between the UART command/response interface and the capture controller and channel RAMs. It also supports per-channel validation and partial (last-N-sample) dumps.

## Interface
- NUM_CH, 5, number of channel RAMs/trigger configs, legal 1..7
- ENTRIES, 384, samples per channel RAM
- LOG2, 9, address width, ceil(log2(ENTRIES))
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cmd  in  16  host command: [15:14] op, [13:8] reg addr / [10:8] dump channel, [7:0] data / dump length
- cmd_rdy  in  1  cmd valid; held until clr_cmd_rdy
- resp_sent  in  1  one-cycle pulse: UART finished sending resp
- set_capture_done  in  1  sets TrigCfg[5]
- ram_addr  in  LOG2  address of newest captured sample
- rdata  in  8*NUM_CH  channel RAM read data, channel k in [8k-1:8k-8]; valid one cycle after addr_ptr changes
- addr_ptr  out  LOG2  RAM read address, reset 0
- TrigCfg  out  6  reset 0x03
- ch_trig_cfg  out  5*NUM_CH  channel k config in [5k-1:5k-5], each resets 0x01
- decimator  out  4  reset 0x0
- VIH / VIL  out  8 each  reset 0xAA / 0x55
- matchH, matchL, maskH, maskL  out  8 each  reset 0x00
- baud_cntH / baud_cntL  out  8 each  reset 0x06 / 0xC8
- trig_pos  out  LOG2  {trig_posH,trig_posL}[LOG2-1:0], reset 0x001
- resp  out  8  registered response byte, reset 0x00
- send_resp  out  1  registered one-cycle pulse, reset 0
- clr_cmd_rdy  out  1  one-cycle pulse, combinational from state and resp_sent, reset-state 0

## Operation
- Register map: 0x00 TrigCfg; 0x01..NUM_CH channel configs; 0x10 decimator, 0x11 VIH, 0x12 VIL, 0x13 matchH, 0x14 matchL, 0x15 maskH, 0x16 maskL, 0x17 baud_cntH, 0x18 baud_cntL, 0x19 trig_posH, 0x1A trig_posL. Other addresses invalid.
- Ops: 00 read, 01 write, 10 dump, 11 NACK (resp 0xEE).
- Read: resp = register zero-extended to 8 bits; invalid addr -> 0xEE.
- Write: valid addr -> register loads data (truncated to width), resp 0xA5; invalid addr -> no write, resp 0xEE.
- set_capture_done coincident with write to 0x00: TrigCfg[4:0] take data, TrigCfg[5] = 1.
- Dump: channel c = cmd[10:8]; c == 0 or c > NUM_CH -> resp 0xEE, no RAM reads. Length N = ENTRIES (see Configuration). First address = (ram_addr - N + 1) mod ENTRIES; bytes go oldest to newest, ending at ram_addr.
- States: IDLE, RESP, DMP_RD, DMP_SEND, DMP_WAIT.
  - IDLE: cmd_rdy low -> stay. Read/write/NACK/invalid dump -> load resp, pulse send_resp, go RESP. Valid dump -> latch c and N into byte counter (LOG2+1 bits), load addr_ptr, go DMP_RD.
  - RESP: on resp_sent, pulse clr_cmd_rdy and go IDLE.
  - DMP_RD: one wait cycle, then go DMP_SEND.
  - DMP_SEND: resp <= channel c byte of rdata; pulse send_resp; addr_ptr increments, wrapping ENTRIES-1 -> 0; counter decrements; go DMP_WAIT.
  - DMP_WAIT: on resp_sent: if counter == 0, pulse clr_cmd_rdy and go IDLE; else go DMP_RD.
- cmd is sampled at IDLE only; changes during dump are ignored.

## Timing
- cmd_rdy seen in IDLE at edge T -> register write and resp/send_resp visible after T+1 edge; clr_cmd_rdy is asserted in the same cycle resp_sent is seen.
- Dump: first send_resp 2 cycles after cmd accepted; between bytes send_resp follows resp_sent by 2 cycles.
- rst_n low at any edge, including mid-dump: every register returns to reset value and state becomes IDLE at that edge; send_resp and clr_cmd_rdy are 0 the next cycle.

## Configuration
- CMDP_PARTIAL_DUMP_EN defined: cmd[7:0] == 0 -> N = ENTRIES; otherwise N = min(cmd[7:0], ENTRIES).
- Not defined: cmd[7:0] is ignored for dumps and N = ENTRIES always.

## Test plan
- Reset, then read 0x00, 0x01, 0x17, 0x18 -> resp 0x03, 0x01, 0x06, 0xC8; each followed by clr_cmd_rdy after resp_sent.
- Write 0x11 = 0x80, then read 0x11 -> resp 0xA5, then 0x80. Write 0x0F = 0x12 -> resp 0xEE and no register changes.
- set_capture_done coincident with write 0x00 = 0x05 -> TrigCfg = 0x25.
- NUM_CH = 5, ram_addr = 383, full dump of ch 3 -> 384 bytes, addr_ptr sequence 0..383; clr_cmd_rdy only after the 384th resp_sent.
- CMDP_PARTIAL_DUMP_EN, ram_addr = 2, dump ch 1 with length 5 -> addresses 382, 383, 0, 1, 2. Dump to channel 6 -> single 0xEE.
- rst_n low in the middle of a dump -> outputs return to reset values; a following read of 0x00 responds normally.

Source files
------------

// File: rtl/cmd_proc_mc_if.sv
// -----------------------------------------------------------------------------
// cmd_proc_mc_if
// Host-side command/response handshake between the UART wrapper and the
// command processor.
//   cmd          16  host command word (op / reg addr or dump channel / data)
//   cmd_rdy       1  command valid, held by the host until clr_cmd_rdy
//   clr_cmd_rdy   1  one-cycle pulse: command fully serviced
//   resp          8  response byte
//   send_resp     1  one-cycle pulse: resp is ready to transmit
//   resp_sent     1  one-cycle pulse: UART finished transmitting resp
// master = UART wrapper side, slave = command processor side.
// -----------------------------------------------------------------------------
interface cmd_proc_mc_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    modport master (
        output cmd, cmd_rdy, resp_sent,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        input  cmd, cmd_rdy, resp_sent,
        output clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/cmd_proc_mc.sv
// -----------------------------------------------------------------------------
// cmd_proc_mc
// Logic-analyzer command processor: decodes host commands, owns the trigger /
// capture configuration registers and streams channel RAM samples to the host.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   host (slave modport)  cmd / cmd_rdy / clr_cmd_rdy / resp / send_resp / resp_sent
//   set_capture_done      sets TrigCfg[5]
//   ram_addr              address of the newest captured sample
//   rdata                 channel RAM read data, channel k at [8k+7:8k] (0-based)
//   addr_ptr              RAM read address
//   TrigCfg, ch_trig_cfg, decimator, VIH, VIL, matchH, matchL, maskH, maskL,
//   baud_cntH, baud_cntL, trig_pos   configuration register outputs
// Optional feature: define CMDP_PARTIAL_DUMP_EN to honour cmd[7:0] as the dump
// length (last-N samples); otherwise every dump returns ENTRIES samples.
// -----------------------------------------------------------------------------
module cmd_proc_mc #(
    parameter int NUM_CH  = 5,
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cmd_proc_mc_if.slave          host,
    input  logic                  set_capture_done,
    input  logic [LOG2-1:0]       ram_addr,
    input  logic [8*NUM_CH-1:0]   rdata,
    output logic [LOG2-1:0]       addr_ptr,
    output logic [5:0]            TrigCfg,
    output logic [5*NUM_CH-1:0]   ch_trig_cfg,
    output logic [3:0]            decimator,
    output logic [7:0]            VIH,
    output logic [7:0]            VIL,
    output logic [7:0]            matchH,
    output logic [7:0]            matchL,
    output logic [7:0]            maskH,
    output logic [7:0]            maskL,
    output logic [7:0]            baud_cntH,
    output logic [7:0]            baud_cntL,
    output logic [LOG2-1:0]       trig_pos
);

    typedef enum logic [2:0] {IDLE, RESP, DMP_RD, DMP_SEND, DMP_WAIT} state_t;

    state_t            state_r;
    logic [4:0]        ch_cfg_r [NUM_CH];
    logic [7:0]        trig_posh_r;
    logic [7:0]        trig_posl_r;
    logic [2:0]        dmp_ch_r;
    logic [LOG2:0]     dmp_cnt_r;

    logic [1:0]        op_s;
    logic [5:0]        addr_s;
    logic [7:0]        data_s;
    logic [2:0]        dch_s;
    logic              accept_s;
    logic              addr_ok_s;
    logic [7:0]        rd_val_s;
    logic [7:0]        resp_val_s;
    logic              wr_en_s;
    logic              dump_ok_s;
    logic [LOG2:0]     n_s;
    logic [LOG2+1:0]   start_sum_s;
    logic [LOG2-1:0]   start_s;
    logic [7:0]        dmp_byte_s;

    assign op_s     = host.cmd[15:14];
    assign addr_s   = host.cmd[13:8];
    assign data_s   = host.cmd[7:0];
    assign dch_s    = host.cmd[10:8];
    assign accept_s = (state_r == IDLE) && host.cmd_rdy;
    assign wr_en_s  = accept_s && (op_s == 2'b01) && addr_ok_s;
    assign trig_pos = LOG2'({trig_posh_r, trig_posl_r});

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
        assign ch_trig_cfg[5*g +: 5] = ch_cfg_r[g];
    end

    // Command is complete once the UART reports the final byte sent.
    assign host.clr_cmd_rdy = host.resp_sent &&
                              ((state_r == RESP) ||
                               ((state_r == DMP_WAIT) && (dmp_cnt_r == '0)));

    // Register-map read mux and address validity.
    always_comb begin
        addr_ok_s = 1'b1;
        rd_val_s  = 8'h00;
        case (addr_s)
            6'h00:   rd_val_s = {2'b00, TrigCfg};
            6'h10:   rd_val_s = {4'h0, decimator};
            6'h11:   rd_val_s = VIH;
            6'h12:   rd_val_s = VIL;
            6'h13:   rd_val_s = matchH;
            6'h14:   rd_val_s = matchL;
            6'h15:   rd_val_s = maskH;
            6'h16:   rd_val_s = maskL;
            6'h17:   rd_val_s = baud_cntH;
            6'h18:   rd_val_s = baud_cntL;
            6'h19:   rd_val_s = trig_posh_r;
            6'h1A:   rd_val_s = trig_posl_r;
            default: begin
                // Channel configs occupy 0x01..NUM_CH; anything else is invalid.
                addr_ok_s = 1'b0;
                for (int k = 0; k < NUM_CH; k++) begin
                    addr_ok_s = addr_ok_s | (addr_s == 6'(k + 1));
                    rd_val_s  = (addr_s == 6'(k + 1)) ? {3'b000, ch_cfg_r[k]} : rd_val_s;
                end
            end
        endcase
    end

    // Single-byte response for read / write / NACK / rejected dump.
    always_comb begin
        case (op_s)
            2'b00:   resp_val_s = addr_ok_s ? rd_val_s : 8'hEE;
            2'b01:   resp_val_s = addr_ok_s ? 8'hA5 : 8'hEE;
            default: resp_val_s = 8'hEE;
        endcase
    end

    // Dump decode: channel validity, length and oldest-sample start address.
    always_comb begin
        dump_ok_s = (dch_s != 3'd0) && (int'(dch_s) <= NUM_CH);
`ifdef CMDP_PARTIAL_DUMP_EN
        if (data_s == 8'd0) begin
            n_s = (LOG2+1)'(ENTRIES);
        end else if (int'(data_s) > ENTRIES) begin
            n_s = (LOG2+1)'(ENTRIES);
        end else begin
            n_s = (LOG2+1)'(data_s);
        end
`else
        n_s = (LOG2+1)'(ENTRIES);
`endif
        // ram_addr + ENTRIES + 1 - N stays below 2*ENTRIES, so one
        // conditional subtract is enough to wrap it.
        start_sum_s = (LOG2+2)'(ram_addr) + (LOG2+2)'(ENTRIES) + (LOG2+2)'(1) - (LOG2+2)'(n_s);
        if (start_sum_s >= (LOG2+2)'(ENTRIES)) begin
            start_s = LOG2'(start_sum_s - (LOG2+2)'(ENTRIES));
        end else begin
            start_s = LOG2'(start_sum_s);
        end
    end

    // Select the latched channel's byte from the RAM read bus.
    always_comb begin
        dmp_byte_s = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            dmp_byte_s = (dmp_ch_r == 3'(k + 1)) ? rdata[8*k +: 8] : dmp_byte_s;
        end
    end

    // Configuration register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            TrigCfg     <= 6'h03;
            decimator   <= 4'h0;
            VIH         <= 8'hAA;
            VIL         <= 8'h55;
            matchH      <= 8'h00;
            matchL      <= 8'h00;
            maskH       <= 8'h00;
            maskL       <= 8'h00;
            baud_cntH   <= 8'h06;
            baud_cntL   <= 8'hC8;
            trig_posh_r <= 8'h00;
            trig_posl_r <= 8'h01;
            for (int k = 0; k < NUM_CH; k++) begin
                ch_cfg_r[k] <= 5'h01;
            end
        end else begin
            // Capture-done wins bit 5 even when the host writes TrigCfg.
            if (wr_en_s && (addr_s == 6'h00)) begin
                TrigCfg <= {data_s[5] | set_capture_done, data_s[4:0]};
            end else if (set_capture_done) begin
                TrigCfg[5] <= 1'b1;
            end
            if (wr_en_s) begin
                case (addr_s)
                    6'h10:   decimator   <= data_s[3:0];
                    6'h11:   VIH         <= data_s;
                    6'h12:   VIL         <= data_s;
                    6'h13:   matchH      <= data_s;
                    6'h14:   matchL      <= data_s;
                    6'h15:   maskH       <= data_s;
                    6'h16:   maskL       <= data_s;
                    6'h17:   baud_cntH   <= data_s;
                    6'h18:   baud_cntL   <= data_s;
                    6'h19:   trig_posh_r <= data_s;
                    6'h1A:   trig_posl_r <= data_s;
                    default: begin end
                endcase
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en_s && (addr_s == 6'(k + 1))) begin
                    ch_cfg_r[k] <= data_s[4:0];
                end
            end
        end
    end

    // Command / dump sequencer with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            host.resp      <= 8'h00;
            host.send_resp <= 1'b0;
            addr_ptr       <= '0;
            dmp_ch_r       <= 3'd0;
            dmp_cnt_r      <= '0;
        end else begin
            host.send_resp <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if ((op_s == 2'b10) && dump_ok_s) begin
                            dmp_ch_r  <= dch_s;
                            dmp_cnt_r <= n_s;
                            addr_ptr  <= start_s;
                            state_r   <= DMP_RD;
                        end else begin
                            host.resp      <= resp_val_s;
                            host.send_resp <= 1'b1;
                            state_r        <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (host.resp_sent) begin
                        state_r <= IDLE;
                    end
                end
                DMP_RD: begin
                    // RAM read data for addr_ptr settles during this cycle.
                    state_r <= DMP_SEND;
                end
                DMP_SEND: begin
                    host.resp      <= dmp_byte_s;
                    host.send_resp <= 1'b1;
                    addr_ptr       <= (addr_ptr == LOG2'(ENTRIES - 1)) ? '0 : addr_ptr + LOG2'(1);
                    dmp_cnt_r      <= dmp_cnt_r - (LOG2+1)'(1);
                    state_r        <= DMP_WAIT;
                end
                DMP_WAIT: begin
                    if (host.resp_sent) begin
                        state_r <= (dmp_cnt_r == '0) ? IDLE : DMP_RD;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_proc_mc.sv
module tb_cmd_proc_mc;
    localparam int NUM_CH  = 5;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_proc_mc_if bus();
    logic                set_capture_done;
    logic [LOG2-1:0]     ram_addr;
    logic [8*NUM_CH-1:0] rdata;
    logic [LOG2-1:0]     addr_ptr;
    logic [5:0]          TrigCfg;
    logic [5*NUM_CH-1:0] ch_trig_cfg;
    logic [3:0]          decimator;
    logic [7:0]          VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL;
    logic [LOG2-1:0]     trig_pos;

    cmd_proc_mc #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .host(bus),
        .set_capture_done(set_capture_done), .ram_addr(ram_addr), .rdata(rdata),
        .addr_ptr(addr_ptr), .TrigCfg(TrigCfg), .ch_trig_cfg(ch_trig_cfg),
        .decimator(decimator), .VIH(VIH), .VIL(VIL), .matchH(matchH), .matchL(matchL),
        .maskH(maskH), .maskL(maskL), .baud_cntH(baud_cntH), .baud_cntL(baud_cntL),
        .trig_pos(trig_pos)
    );

    typedef struct {
        int b;
        bit has_a;
        int a;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    bit   done_f = 1'b0;
    int   mreg [0:31];

    // Channel RAM contents: an arbitrary function of channel and address.
    function automatic int ram_byte(input int k, input int a);
        return (a * 13 + k * 57 + (a / 256) * 101 + 7) & 255;
    endfunction

    // Synchronous-read channel RAMs.
    always @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) rdata[8*k +: 8] <= 8'(ram_byte(k, int'(addr_ptr)));
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit valid_a(input int a);
        return (a == 0) || (a >= 1 && a <= NUM_CH) || (a >= 16 && a <= 26);
    endfunction

    function automatic int mask_a(input int a);
        if (a == 0) return 'h3F;
        if (a >= 1 && a <= NUM_CH) return 'h1F;
        if (a == 16) return 'h0F;
        return 'hFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        mreg[0] = 'h03;
        for (int i = 1; i <= NUM_CH; i++) mreg[i] = 'h01;
        mreg[17] = 'hAA; mreg[18] = 'h55; mreg[23] = 'h06; mreg[24] = 'hC8; mreg[26] = 'h01;
    endtask

    function automatic int dump_len(input int d);
`ifdef CMDP_PARTIAL_DUMP_EN
        if (d == 0 || d > ENTRIES) return ENTRIES;
        return d;
`else
        return ENTRIES;
`endif
    endfunction

    // Reference model: update registers and queue every byte the host should see.
    task automatic expect_resp(input int c, input bit capdone);
        int op, a, d, ch, n, ad;
        op = (c >> 14) & 3; a = (c >> 8) & 63; d = c & 255; ch = (c >> 8) & 7;
        case (op)
            0: sbq.push_back('{valid_a(a) ? mreg[a] : 'hEE, 1'b0, 0});
            1: begin
                if (valid_a(a)) begin
                    mreg[a] = d & mask_a(a);
                    sbq.push_back('{'hA5, 1'b0, 0});
                end else begin
                    sbq.push_back('{'hEE, 1'b0, 0});
                end
            end
            2: begin
                if (ch == 0 || ch > NUM_CH) begin
                    sbq.push_back('{'hEE, 1'b0, 0});
                end else begin
                    n = dump_len(d);
                    for (int i = 0; i < n; i++) begin
                        ad = ((int'(ram_addr) - n + 1 + i) % ENTRIES + ENTRIES) % ENTRIES;
                        sbq.push_back('{ram_byte(ch - 1, ad), 1'b1, (ad + 1) % ENTRIES});
                    end
                end
            end
            default: sbq.push_back('{'hEE, 1'b0, 0});
        endcase
        if (capdone) mreg[0] = mreg[0] | 'h20;
    endtask

    task automatic check_regs();
        chk("TrigCfg", int'(TrigCfg), mreg[0]);
        for (int k = 0; k < NUM_CH; k++) chk($sformatf("ch_trig_cfg%0d", k + 1), int'(ch_trig_cfg[5*k +: 5]), mreg[k + 1]);
        chk("decimator", int'(decimator), mreg[16]);
        chk("VIH", int'(VIH), mreg[17]);
        chk("VIL", int'(VIL), mreg[18]);
        chk("matchH", int'(matchH), mreg[19]);
        chk("matchL", int'(matchL), mreg[20]);
        chk("maskH", int'(maskH), mreg[21]);
        chk("maskL", int'(maskL), mreg[22]);
        chk("baud_cntH", int'(baud_cntH), mreg[23]);
        chk("baud_cntL", int'(baud_cntL), mreg[24]);
        chk("trig_pos", int'(trig_pos), ((mreg[25] << 8) | mreg[26]) & ((1 << LOG2) - 1));
    endtask

    // Monitor: every send_resp pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.send_resp === 1'b1) begin
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_resp actual=0x%0h expected=none", bus.resp);
                end else begin
                    e = sbq.pop_front();
                    chk("resp", int'(bus.resp), e.b);
                    if (e.has_a) chk("addr_ptr", int'(addr_ptr), e.a);
                end
            end
        end
    end

    // UART model: acknowledges each byte after a random delay and checks that
    // clr_cmd_rdy comes exactly with the final byte's resp_sent.
    initial begin
        bus.resp_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.send_resp === 1'b1) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                bus.resp_sent = 1'b1;
                #1;
                if (chk_en) begin
                    chk("clr_cmd_rdy", int'(bus.clr_cmd_rdy), (sbq.size() == 0) ? 1 : 0);
                    if (bus.clr_cmd_rdy === 1'b1) done_f = 1'b1;
                end
                @(negedge clk);
                bus.resp_sent = 1'b0;
            end
        end
    end

    task automatic issue(input logic [15:0] c, input bit capdone);
        expect_resp(int'(c), capdone);
        done_f = 1'b0;
        @(negedge clk);
        bus.cmd = c; bus.cmd_rdy = 1'b1; set_capture_done = capdone;
        @(negedge clk);
        set_capture_done = 1'b0;
        for (int i = 0; i < 6000 && !done_f; i++) @(negedge clk);
        if (!done_f) begin
            tests++; fails++;
            $display("FAIL cmd_timeout cmd=0x%0h no clr_cmd_rdy within bound", c);
        end
        bus.cmd_rdy = 1'b0;
        chk("queue_drained", sbq.size(), 0);
        sbq.delete();
        check_regs();
    endtask

    initial begin
        int op, a, d, nq;
        logic [15:0] c;
        int vlist [12] = '{0, 1, 2, 3, 4, 5, 16, 17, 20, 23, 25, 26};
        bus.cmd = 16'h0000; bus.cmd_rdy = 1'b0;
        set_capture_done = 1'b0; ram_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs();
        chk("rst_resp", int'(bus.resp), 0);
        chk("rst_send_resp", int'(bus.send_resp), 0);
        chk("rst_addr_ptr", int'(addr_ptr), 0);
        chk("rst_clr", int'(bus.clr_cmd_rdy), 0);
        chk_en = 1'b1;

        issue(16'h0000, 1'b0);
        issue(16'h0100, 1'b0);
        issue(16'h1700, 1'b0);
        issue(16'h1800, 1'b0);
        issue(16'h5180, 1'b0);
        issue(16'h1100, 1'b0);
        issue(16'h4F12, 1'b0);
        issue(16'h4005, 1'b1);
        issue(16'h0000, 1'b0);
        // Standalone capture-done pulse.
        @(negedge clk); set_capture_done = 1'b1; mreg[0] = mreg[0] | 'h20;
        @(negedge clk); set_capture_done = 1'b0;
        issue(16'h4003, 1'b0);
        @(negedge clk); set_capture_done = 1'b1; mreg[0] = mreg[0] | 'h20;
        @(negedge clk); set_capture_done = 1'b0;
        issue(16'h0000, 1'b0);

        ram_addr = 9'(ENTRIES - 1);
        issue(16'h8300, 1'b0);
        ram_addr = 9'd2;
        issue(16'h8105, 1'b0);
        issue(16'h8600, 1'b0);
        issue(16'h8000, 1'b0);
        issue(16'hC000, 1'b0);

        // Reset in the middle of a dump.
        ram_addr = 9'd100;
        expect_resp(16'h8200, 1'b0);
        nq = sbq.size();
        @(negedge clk);
        bus.cmd = 16'h8200; bus.cmd_rdy = 1'b1;
        for (int i = 0; i < 300 && sbq.size() > nq - 5; i++) @(negedge clk);
        chk_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_send_resp", int'(bus.send_resp), 0);
        chk("mid_rst_clr", int'(bus.clr_cmd_rdy), 0);
        rst_n = 1'b1; bus.cmd_rdy = 1'b0;
        repeat (8) @(negedge clk);
        sbq.delete();
        model_reset();
        check_regs();
        chk("mid_rst_addr_ptr", int'(addr_ptr), 0);
        chk("mid_rst_resp", int'(bus.resp), 0);
        chk_en = 1'b1;
        issue(16'h0000, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            op = $urandom_range(0, 3);
            a  = ($urandom_range(0, 1) == 0) ? vlist[$urandom_range(0, 11)] : $urandom_range(0, 63);
            d  = $urandom_range(0, 255);
            if (op == 2) ram_addr = 9'($urandom_range(0, ENTRIES - 1));
            c = 16'((op << 14) | (a << 8) | d);
            issue(c, $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
